// File: rtl/pci_emu_initiator_if.sv
// Request/response handshake and bus control lines of the emulated PCI initiator.
// AD is a shared tristate net and stays a plain port on the initiator.
interface pci_emu_initiator_if;
  logic        REQ;
  logic        REQ_WR;
  logic [23:0] REQ_ADDR;
  logic [23:0] REQ_WDATA;
  logic        BUSY;
  logic        DONE;
  logic [23:0] RDATA;
  logic        CS;
  logic        RD_WR;
  logic        ADDR_DATA_SEL;
  logic [2:0]  BYTE_SEL;

  modport master (
    input  REQ, REQ_WR, REQ_ADDR, REQ_WDATA,
    output BUSY, DONE, RDATA, CS, RD_WR, ADDR_DATA_SEL, BYTE_SEL
  );

  modport slave (
    output REQ, REQ_WR, REQ_ADDR, REQ_WDATA,
    input  BUSY, DONE, RDATA, CS, RD_WR, ADDR_DATA_SEL, BYTE_SEL
  );
endinterface

// File: rtl/pci_emu_initiator.sv
// Host-side master for the byte-wide emulated PCI bus: serialises one 24-bit
// read or write into byte-select cycles and returns read data.
module pci_emu_initiator #(
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                   PCI_CLK2,
  input  logic                   OPB_RST,
  pci_emu_initiator_if.master    bus,
  inout  wire  [7:0]             AD
);

  typedef enum logic [3:0] {
    S_IDLE, S_ALOAD, S_AGAP, S_ACOMMIT, S_WLOAD,
    S_WCOMMIT, S_WSTROBE, S_RWAIT, S_RSAMPLE, S_END
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [23:0] addr_q, wdata_q, rdata_q;
  logic [15:0] shadow;
  logic        cs, rd_wr, ads, ad_oe;
  logic [2:0]  bsel;
  logic [7:0]  ad_out;
  logic [1:0]  lane;

  function automatic logic [7:0] pick(input logic [23:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick = w[7:0];
      2'd1:    pick = w[15:8];
      default: pick = w[23:16];
    endcase
  endfunction

  // Lane codes: load = {lane,1}, read = {lane,0}, lane counting 1..3.
  assign lane = cnt[1:0] + 2'd1;

  always_ff @(posedge PCI_CLK2 or posedge OPB_RST) begin
    if (OPB_RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == S_IDLE) cnt <= '0;
      else                                      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge PCI_CLK2 or posedge OPB_RST) begin
    if (OPB_RST) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      shadow  <= '0;
      rdata_q <= '0;
    end else begin
      if (state == S_IDLE && bus.REQ) begin
        wr_q    <= bus.REQ_WR;
        addr_q  <= bus.REQ_ADDR;
        wdata_q <= bus.REQ_WDATA;
      end
      // Last lane goes straight into RDATA so it is visible with DONE.
      if (state == S_RSAMPLE) begin
        case (cnt[1:0])
          2'd0:    shadow[7:0]  <= AD;
          2'd1:    shadow[15:8] <= AD;
          default: rdata_q      <= {AD, shadow};
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    cs       = 1'b1;
    rd_wr    = 1'b0;
    ads      = 1'b0;
    bsel     = 3'b000;
    ad_oe    = 1'b0;
    ad_out   = '0;
    case (state)
      S_IDLE: if (bus.REQ) state_nx = S_ALOAD;
      S_ALOAD: begin
        cs     = 1'b0;
        bsel   = {lane, 1'b1};
        ad_oe  = 1'b1;
        ad_out = pick(addr_q, cnt[1:0]);
        if (cnt == 4'd2) state_nx = S_AGAP;
      end
      S_AGAP: begin
        bsel = 3'b001;
        if (cnt == 4'(GAP_CYCLES - 1)) state_nx = S_ACOMMIT;
      end
      S_ACOMMIT: begin
        cs       = 1'b0;
        bsel     = 3'b001;
        rd_wr    = ~wr_q;
        ad_oe    = wr_q;
        state_nx = wr_q ? S_WLOAD : S_RWAIT;
      end
      S_WLOAD: begin
        cs     = 1'b0;
        bsel   = {lane, 1'b1};
        ad_oe  = 1'b1;
        ad_out = pick(wdata_q, cnt[1:0]);
        if (cnt == 4'd2) state_nx = S_WCOMMIT;
      end
      S_WCOMMIT: begin
        cs       = 1'b0;
        ads      = 1'b1;
        bsel     = 3'b001;
        ad_oe    = 1'b1;
        state_nx = S_WSTROBE;
      end
      S_WSTROBE: begin
        cs       = 1'b0;
        ads      = 1'b1;
        ad_oe    = 1'b1;
        state_nx = S_END;
      end
      S_RWAIT: begin
        cs    = 1'b0;
        rd_wr = 1'b1;
        bsel  = 3'b001;
        if (cnt == 4'(RD_WAIT - 1)) state_nx = S_RSAMPLE;
      end
      S_RSAMPLE: begin
        cs    = 1'b0;
        rd_wr = 1'b1;
        bsel  = {lane, 1'b0};
        if (cnt == 4'd2) state_nx = S_END;
      end
      S_END:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign AD                = ad_oe ? ad_out : 'z;
  assign bus.CS            = cs;
  assign bus.RD_WR         = rd_wr;
  assign bus.ADDR_DATA_SEL = ads;
  assign bus.BYTE_SEL      = bsel;
  assign bus.BUSY          = (state != S_IDLE);
  assign bus.DONE          = (state == S_END);
  assign bus.RDATA         = rdata_q;

endmodule
